// File: rtl/alut_pkg8.sv
// Shared definitions for the ALUT lookup initiator: register map, command code,
// FSM/step encodings and the step-to-APB decode helpers.
package alut_pkg8;

    localparam logic [6:0] ADDR_COMMAND  = 7'h00;
    localparam logic [6:0] ADDR_D_ADDR_L = 7'h08;
    localparam logic [6:0] ADDR_D_ADDR_H = 7'h0C;
    localparam logic [6:0] ADDR_S_ADDR_L = 7'h10;
    localparam logic [6:0] ADDR_S_ADDR_H = 7'h14;
    localparam logic [6:0] ADDR_S_PORT   = 7'h18;
    localparam logic [6:0] ADDR_STATUS   = 7'h1C;
    localparam logic [6:0] ADDR_D_PORT   = 7'h20;

    localparam logic [1:0] CMD_CHECK = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } alut_state_e;

    // Step order is the on-bus order: six operand/command writes, then the reads.
    typedef enum logic [2:0] {
        STEP_D_ADDR_L = 3'd0,
        STEP_D_ADDR_H = 3'd1,
        STEP_S_ADDR_L = 3'd2,
        STEP_S_ADDR_H = 3'd3,
        STEP_S_PORT   = 3'd4,
        STEP_COMMAND  = 3'd5,
        STEP_STATUS   = 3'd6,
        STEP_D_PORT   = 3'd7
    } alut_step_e;

    function automatic logic [6:0] step_addr(input alut_step_e step);
        logic [6:0] addr;
        case (step)
            STEP_D_ADDR_L: addr = ADDR_D_ADDR_L;
            STEP_D_ADDR_H: addr = ADDR_D_ADDR_H;
            STEP_S_ADDR_L: addr = ADDR_S_ADDR_L;
            STEP_S_ADDR_H: addr = ADDR_S_ADDR_H;
            STEP_S_PORT:   addr = ADDR_S_PORT;
            STEP_COMMAND:  addr = ADDR_COMMAND;
            STEP_STATUS:   addr = ADDR_STATUS;
            default:       addr = ADDR_D_PORT;
        endcase
        return addr;
    endfunction

    function automatic logic [31:0] step_wdata(input alut_step_e step, input logic [47:0] d_addr,
                                               input logic [47:0] s_addr, input logic [1:0] s_port);
        logic [31:0] data;
        case (step)
            STEP_D_ADDR_L: data = d_addr[31:0];
            STEP_D_ADDR_H: data = {16'h0, d_addr[47:32]};
            STEP_S_ADDR_L: data = s_addr[31:0];
            STEP_S_ADDR_H: data = {16'h0, s_addr[47:32]};
            STEP_S_PORT:   data = {30'h0, s_port};
            STEP_COMMAND:  data = {30'h0, CMD_CHECK};
            default:       data = 32'h0;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/alut_apb_xfer8.sv
// Single APB transfer engine (no pready): SETUP then ACCESS, with a new start
// accepted in the ACCESS cycle so transfers can run back-to-back.
module alut_apb_xfer8 (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_write,
    input  logic [6:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_xfer_done,
    output logic        o_psel,
    output logic        o_penable,
    output logic        o_pwrite,
    output logic [6:0]  o_paddr,
    output logic [31:0] o_pwdata,
    input  logic [31:0] i_prdata
);

    logic        r_psel;
    logic        r_penable;
    logic        r_pwrite;
    logic [6:0]  r_paddr;
    logic [31:0] r_pwdata;

    // Address/data/direction only load on start, so they hold while idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= 7'h0;
            r_pwdata  <= 32'h0;
        end else if (i_start) begin
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_pwrite  <= i_write;
            r_paddr   <= i_addr;
            r_pwdata  <= i_wdata;
        end else if (r_psel && !r_penable) begin
            r_penable <= 1'b1;
        end else if (r_penable) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
        end
    end

    // Read data is consumed on the edge that closes ACCESS.
    assign o_rdata     = i_prdata;
    assign o_xfer_done = r_psel & r_penable;
    assign o_psel      = r_psel;
    assign o_penable   = r_penable;
    assign o_pwrite    = r_pwrite;
    assign o_paddr     = r_paddr;
    assign o_pwdata    = r_pwdata;

endmodule

// File: rtl/alut_lookup_req8.sv
// Lookup request sequencer: writes operands and CHECK command to the ALUT,
// polls STATUS until idle (or POLL_MAX), reads D_PORT and pulses done8.
module alut_lookup_req8
    import alut_pkg8::*;
#(
    parameter int unsigned POLL_MAX = 255
) (
    input  logic        pclk8,
    input  logic        n_p_reset8,
    input  logic        req8,
    input  logic [47:0] d_addr_in8,
    input  logic [47:0] s_addr_in8,
    input  logic [1:0]  s_port_in8,
    output logic        busy8,
    output logic        done8,
    output logic [4:0]  d_port_out8,
    output logic        timeout8,
    output logic        psel8,
    output logic        penable8,
    output logic        pwrite8,
    output logic [6:0]  paddr8,
    output logic [31:0] pwdata8,
    input  logic [31:0] prdata8
);

    localparam logic [7:0] POLL_LIMIT = 8'(POLL_MAX);

    alut_state_e r_state;
    alut_state_e w_state_nxt;
    alut_step_e  r_step;
    alut_step_e  w_step_nxt;
    logic [7:0]  r_poll_cnt;
    logic [7:0]  w_poll_cnt_inc;
    logic [47:0] r_d_addr;
    logic [47:0] r_s_addr;
    logic [1:0]  r_s_port;
    logic [4:0]  r_d_port;
    logic        r_timeout;
    logic        w_accept;
    logic        w_start;
    logic        w_finish;
    logic        w_timeout_hit;
    logic        w_xfer_done;
    logic [31:0] w_rdata;
    logic [47:0] w_d_sel;
    logic [47:0] w_s_sel;
    logic [1:0]  w_port_sel;

    assign busy8       = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign done8       = (r_state == ST_DONE);
    assign d_port_out8 = r_d_port;
    assign timeout8    = r_timeout;

    assign w_accept       = req8 && !busy8;
    assign w_poll_cnt_inc = (r_poll_cnt == POLL_LIMIT) ? r_poll_cnt : r_poll_cnt + 8'd1;

    // The first SETUP launches on the accept edge, before operands are latched.
    assign w_d_sel    = w_accept ? d_addr_in8 : r_d_addr;
    assign w_s_sel    = w_accept ? s_addr_in8 : r_s_addr;
    assign w_port_sel = w_accept ? s_port_in8 : r_s_port;

    always_comb begin
        w_state_nxt   = r_state;
        w_step_nxt    = r_step;
        w_start       = 1'b0;
        w_finish      = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (w_accept) begin
                    w_state_nxt = ST_SETUP;
                    w_step_nxt  = STEP_D_ADDR_L;
                    w_start     = 1'b1;
                end
            end
            ST_SETUP: w_state_nxt = ST_ACCESS;
            default: begin
                if (w_xfer_done) begin
                    case (r_step)
                        STEP_D_PORT: w_finish = 1'b1;
                        STEP_STATUS: begin
                            if (!w_rdata[0]) begin
                                w_step_nxt = STEP_D_PORT;
                                w_start    = 1'b1;
                            end else if (w_poll_cnt_inc < POLL_LIMIT) begin
                                w_start = 1'b1;
                            end else begin
                                w_finish      = 1'b1;
                                w_timeout_hit = 1'b1;
                            end
                        end
                        default: begin
                            w_step_nxt = alut_step_e'(r_step + 3'd1);
                            w_start    = 1'b1;
                        end
                    endcase
                    if (w_start)  w_state_nxt = ST_SETUP;
                    if (w_finish) w_state_nxt = ST_DONE;
                end
            end
        endcase
    end

    always_ff @(posedge pclk8 or negedge n_p_reset8) begin
        if (!n_p_reset8) begin
            r_state    <= ST_IDLE;
            r_step     <= STEP_D_ADDR_L;
            r_poll_cnt <= 8'h0;
            r_d_addr   <= 48'h0;
            r_s_addr   <= 48'h0;
            r_s_port   <= 2'h0;
            r_d_port   <= 5'h0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            if (w_accept) begin
                r_d_addr   <= d_addr_in8;
                r_s_addr   <= s_addr_in8;
                r_s_port   <= s_port_in8;
                r_poll_cnt <= 8'h0;
            end else if (r_state == ST_ACCESS && r_step == STEP_STATUS) begin
                r_poll_cnt <= w_poll_cnt_inc;
            end
            if (w_finish) begin
                r_d_port  <= w_timeout_hit ? 5'h0 : w_rdata[4:0];
                r_timeout <= w_timeout_hit;
            end
        end
    end

    alut_apb_xfer8 u_xfer (
        .i_clk       (pclk8),
        .i_rst_n     (n_p_reset8),
        .i_start     (w_start),
        .i_write     (w_step_nxt < STEP_STATUS),
        .i_addr      (step_addr(w_step_nxt)),
        .i_wdata     (step_wdata(w_step_nxt, w_d_sel, w_s_sel, w_port_sel)),
        .o_rdata     (w_rdata),
        .o_xfer_done (w_xfer_done),
        .o_psel      (psel8),
        .o_penable   (penable8),
        .o_pwrite    (pwrite8),
        .o_paddr     (paddr8),
        .o_pwdata    (pwdata8),
        .i_prdata    (prdata8)
    );

endmodule
